// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified memory port arbiter.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    GRANT_IF = 1'b0,
    GRANT_DM = 1'b1
  } grant_e;

  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_LO   = 4'b0011;
  localparam logic [3:0] BE_HI   = 4'b1100;

endpackage

// File: rtl/mem_port_arbiter_lane_align.sv
// Byte-lane placement for writes, lane extraction/extension for reads,
// and the alignment check applied at grant time.
import mem_pkg::*;

module mem_lane_align (
  input  logic [1:0]  wr_addr_lo,
  input  logic        wr_half,
  input  logic [31:0] wr_data,
  output logic [3:0]  wr_be,
  output logic [31:0] wr_data_lane,
  output logic        misaligned,
  input  logic        rd_hi,
  input  logic        rd_half,
  input  logic        rd_unsigned,
  input  logic [31:0] rd_data,
  output logic [31:0] rd_data_ext
);

  logic [15:0] half_sel;

  always_comb begin
    misaligned   = wr_half ? wr_addr_lo[0] : (wr_addr_lo != 2'b00);
    wr_be        = wr_half ? (wr_addr_lo[1] ? BE_HI : BE_LO) : BE_WORD;
    wr_data_lane = wr_half ? {2{wr_data[15:0]}} : wr_data;

    // Little-endian: address bit 1 picks the upper halfword.
    half_sel = rd_hi ? rd_data[31:16] : rd_data[15:0];
    if (!rd_half) begin
      rd_data_ext = rd_data;
    end else if (rd_unsigned) begin
      rd_data_ext = {16'h0000, half_sel};
    end else begin
      rd_data_ext = {{16{half_sel[15]}}, half_sel};
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch
// and load/store traffic, with alignment checking and an access timeout.
import mem_pkg::*;

module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic              dm_half,
  input  logic              dm_unsigned,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  grant_e            grant_q, grant_d;
  grant_e            last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              half_q, half_d;
  logic              uns_q, uns_d;
  logic              hi_q, hi_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic              if_ack_q, if_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              if_err_q, if_err_d;
  logic              dm_ack_q, dm_ack_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              dm_err_q, dm_err_d;

  grant_e            g_owner;
  logic [ADDR_W-1:0] g_addr;
  logic              g_half;
  logic              g_we;
  logic [DATA_W-1:0] g_wdata;
  logic [3:0]        g_be;
  logic [DATA_W-1:0] g_wdata_lane;
  logic              g_misaligned;
  logic [DATA_W-1:0] rd_ext;

  logic              res_valid;
  grant_e            res_owner;
  logic [DATA_W-1:0] res_data;
  logic              res_err;

  // On contention the requester that did not win last time is served.
  assign g_owner = (dm_req && (!if_req || last_grant_q == GRANT_IF)) ? GRANT_DM : GRANT_IF;
  assign g_addr  = (g_owner == GRANT_DM) ? dm_addr : if_addr;
  assign g_half  = (g_owner == GRANT_DM) && dm_half;
  assign g_we    = (g_owner == GRANT_DM) && dm_we;
  assign g_wdata = (g_owner == GRANT_DM) ? dm_wdata : '0;

  mem_lane_align u_align (
    .wr_addr_lo   (g_addr[1:0]),
    .wr_half      (g_half),
    .wr_data      (g_wdata),
    .wr_be        (g_be),
    .wr_data_lane (g_wdata_lane),
    .misaligned   (g_misaligned),
    .rd_hi        (hi_q),
    .rd_half      (half_q),
    .rd_unsigned  (uns_q),
    .rd_data      (mem_rdata),
    .rd_data_ext  (rd_ext)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    half_d       = half_q;
    uns_d        = uns_q;
    hi_d         = hi_q;
    mem_en_d     = mem_en_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    if_ack_d     = 1'b0;
    if_rdata_d   = if_rdata_q;
    if_err_d     = if_err_q;
    dm_ack_d     = 1'b0;
    dm_rdata_d   = dm_rdata_q;
    dm_err_d     = dm_err_q;
    res_valid    = 1'b0;
    res_owner    = grant_q;
    res_data     = '0;
    res_err      = 1'b0;

    case (state_q)
      IDLE: begin
        if (if_req || dm_req) begin
          grant_d      = g_owner;
          last_grant_d = g_owner;
          cnt_d        = '0;
          half_d       = g_half;
          uns_d        = dm_unsigned;
          hi_d         = g_addr[1];
          if (g_misaligned) begin
            state_d   = RESP;
            res_valid = 1'b1;
            res_owner = g_owner;
            res_err   = 1'b1;
          end else begin
            state_d     = ACCESS;
            mem_en_d    = 1'b1;
            mem_we_d    = g_we;
            mem_addr_d  = {g_addr[ADDR_W-1:2], 2'b00};
            mem_be_d    = g_be;
            mem_wdata_d = g_wdata_lane;
          end
        end
      end
      ACCESS: begin
        // mem_ready wins over a timeout landing in the same cycle.
        if (mem_ready) begin
          state_d   = RESP;
          mem_en_d  = 1'b0;
          res_valid = 1'b1;
          res_data  = mem_we_q ? '0 : rd_ext;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d   = RESP;
          mem_en_d  = 1'b0;
          res_valid = 1'b1;
          res_err   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (res_valid) begin
      if (res_owner == GRANT_DM) begin
        dm_ack_d   = 1'b1;
        dm_rdata_d = res_data;
        dm_err_d   = res_err;
      end else begin
        if_ack_d   = 1'b1;
        if_rdata_d = res_data;
        if_err_d   = res_err;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_q      <= GRANT_IF;
      last_grant_q <= GRANT_IF;
      cnt_q        <= '0;
      half_q       <= 1'b0;
      uns_q        <= 1'b0;
      hi_q         <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      if_ack_q     <= 1'b0;
      if_rdata_q   <= '0;
      if_err_q     <= 1'b0;
      dm_ack_q     <= 1'b0;
      dm_rdata_q   <= '0;
      dm_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      half_q       <= half_d;
      uns_q        <= uns_d;
      hi_q         <= hi_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      if_ack_q     <= if_ack_d;
      if_rdata_q   <= if_rdata_d;
      if_err_q     <= if_err_d;
      dm_ack_q     <= dm_ack_d;
      dm_rdata_q   <= dm_rdata_d;
      dm_err_q     <= dm_err_d;
    end
  end

  assign if_ack    = if_ack_q;
  assign if_rdata  = if_rdata_q;
  assign if_err    = if_err_q;
  assign dm_ack    = dm_ack_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_err    = dm_err_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, dm_req, dm_we, dm_half, dm_unsigned;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic        if_ack, if_err, dm_ack, dm_err;
  logic [31:0] if_rdata, dm_rdata;
  logic        mem_en, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_half(dm_half), .dm_unsigned(dm_unsigned),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata), .dm_err(dm_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  // Observations from the last transaction.
  bit          obs_got, obs_wrong, obs_stable, obs_we, obs_err, obs_ack_after, obs_held_err;
  int          obs_lat, obs_en;
  logic [31:0] obs_rdata, obs_maddr, obs_mwdata, obs_held;
  logic [3:0]  obs_be;

  // Expectations from the reference model.
  int          exp_lat, exp_en;
  bit          exp_err, exp_we;
  logic [31:0] exp_rdata, exp_maddr, exp_mwdata;
  logic [3:0]  exp_be;

  task automatic model(input bit is_if, input bit we, input bit half, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rword, input int wait_n);
    bit mis;
    logic [31:0] h;
    bit word = is_if || !half;
    mis        = word ? (addr % 4 != 0) : (addr % 2 != 0);
    exp_we     = !is_if && we;
    exp_maddr  = addr - (addr % 4);
    exp_be     = word ? 4'd15 : (((addr / 2) % 2 == 1) ? 4'd12 : 4'd3);
    exp_mwdata = is_if ? 32'd0 : (word ? wdata : (wdata % 65536) * 65537);
    if (mis) begin
      exp_lat = 1; exp_en = 0; exp_err = 1; exp_rdata = 0;
    end else if (wait_n >= TMO) begin
      exp_lat = TMO + 1; exp_en = TMO; exp_err = 1; exp_rdata = 0;
    end else begin
      exp_lat = wait_n + 2; exp_en = wait_n + 1; exp_err = 0;
      if (exp_we) exp_rdata = 0;
      else if (word) exp_rdata = rword;
      else begin
        h = ((addr / 2) % 2 == 1) ? rword / 65536 : rword % 65536;
        exp_rdata = (uns || h < 32768) ? h : h + 32'hFFFF0000;
      end
    end
  endtask

  // Drives one request and plays a memory that answers after wait_n extra cycles.
  task automatic drive_access(input bit is_if, input bit we, input bit half, input bit uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rword, input int wait_n, input bit stray);
    int n = 0;
    @(negedge clk);
    if (is_if) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      dm_req = 1'b1; dm_we = we; dm_half = half; dm_unsigned = uns;
      dm_addr = addr; dm_wdata = wdata;
    end
    mem_ready = stray;
    obs_got = 0; obs_wrong = 0; obs_stable = 1; obs_en = 0; obs_lat = -1;
    obs_maddr = 0; obs_mwdata = 0; obs_be = 0; obs_we = 0;
    while (!obs_got && n < 40) begin
      @(posedge clk); n++; @(negedge clk);
      if (mem_en) begin
        if (obs_en == 0) begin
          obs_maddr = mem_addr; obs_mwdata = mem_wdata; obs_be = mem_be; obs_we = mem_we;
        end else if (mem_addr !== obs_maddr || mem_be !== obs_be ||
                     mem_wdata !== obs_mwdata || mem_we !== obs_we) begin
          obs_stable = 0;
        end
        obs_en++;
        mem_ready = (obs_en > wait_n);
        mem_rdata = rword;
      end else begin
        mem_ready = stray;
        mem_rdata = $urandom;
      end
      if (is_if ? if_ack : dm_ack) begin
        obs_got = 1; obs_lat = n;
        obs_rdata = is_if ? if_rdata : dm_rdata;
        obs_err   = is_if ? if_err : dm_err;
      end
      if (is_if ? dm_ack : if_ack) obs_wrong = 1;
    end
    if_req = 1'b0; dm_req = 1'b0; mem_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    obs_ack_after = if_ack | dm_ack;
    obs_held      = is_if ? if_rdata : dm_rdata;
    obs_held_err  = is_if ? if_err : dm_err;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    if_req = 0; dm_req = 0; dm_we = 0; dm_half = 0; dm_unsigned = 0;
    if_addr = 0; dm_addr = 0; dm_wdata = 0; mem_ready = 0; mem_rdata = 0;
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    if_req = 0; dm_req = 0; dm_we = 0; dm_half = 0; dm_unsigned = 0;
    if_addr = 0; dm_addr = 0; dm_wdata = 0; mem_ready = 0; mem_rdata = 0;
    #1;
    checks++;
    if ({if_ack, if_rdata, if_err, dm_ack, dm_rdata, dm_err, mem_en, mem_we, mem_addr,
         mem_wdata, mem_be} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got nonzero outputs mem_en=%b if_ack=%b dm_ack=%b", mem_en, if_ack, dm_ack);
    end
    @(negedge clk); reset = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++;
    if (mem_en !== 1'b0 || if_ack !== 1'b0 || dm_ack !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: mem_en=%b if_ack=%b dm_ack=%b expected 0", mem_en, if_ack, dm_ack);
    end
  endtask

  task automatic test_fetch_zero_wait();
    model(1, 0, 0, 0, 32'h40, 0, 32'h2008000A, 0);
    drive_access(1, 0, 0, 0, 32'h40, 0, 32'h2008000A, 0, 0);
    checks++;
    if (!obs_got || obs_lat != exp_lat) begin
      errors++; $display("FAIL fetch_latency: got %0d expected %0d", obs_lat, exp_lat);
    end
    checks++;
    if (obs_rdata !== 32'h2008000A || obs_err !== 1'b0) begin
      errors++; $display("FAIL fetch_data: got %h err=%b expected 2008000a err=0", obs_rdata, obs_err);
    end
    checks++;
    if (obs_maddr !== 32'h40 || obs_be !== 4'hF || obs_we !== 1'b0 || obs_en != 1) begin
      errors++; $display("FAIL fetch_port: addr=%h be=%h we=%b en=%0d expected 40 f 0 1",
                         obs_maddr, obs_be, obs_we, obs_en);
    end
    checks++;
    if (obs_ack_after !== 1'b0 || obs_held !== 32'h2008000A) begin
      errors++; $display("FAIL fetch_ack_pulse: ack_after=%b held=%h expected 0 2008000a", obs_ack_after, obs_held);
    end
  endtask

  task automatic test_halfword_loads();
    logic [31:0] addrs [4] = '{32'h102, 32'h102, 32'h100, 32'h100};
    bit          unss  [4] = '{0, 1, 0, 1};
    for (int i = 0; i < 4; i++) begin
      int w = $urandom_range(0, 2);
      model(0, 0, 1, unss[i], addrs[i], 0, 32'h80011234, w);
      drive_access(0, 0, 1, unss[i], addrs[i], 0, 32'h80011234, w, 0);
      checks++;
      if (!obs_got || obs_rdata !== exp_rdata || obs_err !== 1'b0 || obs_lat != exp_lat) begin
        errors++; $display("FAIL half_load_%0d: got %h err=%b lat=%0d expected %h err=0 lat=%0d",
                           i, obs_rdata, obs_err, obs_lat, exp_rdata, exp_lat);
      end
      checks++;
      if (obs_be !== exp_be || obs_maddr !== 32'h100) begin
        errors++; $display("FAIL half_load_port_%0d: be=%h addr=%h expected %h 100", i, obs_be, obs_maddr, exp_be);
      end
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] addrs [3] = '{32'h101, 32'h103, 32'h42};
    bit          isif  [3] = '{0, 0, 1};
    bit          hlf   [3] = '{0, 1, 0};
    for (int i = 0; i < 3; i++) begin
      drive_access(isif[i], 0, hlf[i], 0, addrs[i], 0, 32'hDEADBEEF, 0, 1);
      checks++;
      if (!obs_got || obs_lat != 1 || obs_en != 0 || obs_err !== 1'b1 || obs_rdata !== 32'h0) begin
        errors++; $display("FAIL misaligned_%0d: lat=%0d en=%0d err=%b rdata=%h expected 1 0 1 0",
                           i, obs_lat, obs_en, obs_err, obs_rdata);
      end
    end
  endtask

  task automatic test_store_half();
    model(0, 1, 1, 0, 32'h106, 32'h0000ABCD, 32'h55555555, 1);
    drive_access(0, 1, 1, 0, 32'h106, 32'h0000ABCD, 32'h55555555, 1, 0);
    checks++;
    if (obs_be !== 4'b1100 || obs_mwdata !== 32'hABCDABCD || obs_maddr !== 32'h104 || obs_we !== 1'b1) begin
      errors++; $display("FAIL store_half_port: be=%b wdata=%h addr=%h we=%b expected 1100 abcdabcd 104 1",
                         obs_be, obs_mwdata, obs_maddr, obs_we);
    end
    checks++;
    if (!obs_got || obs_rdata !== 32'h0 || obs_err !== 1'b0 || obs_lat != exp_lat || !obs_stable) begin
      errors++; $display("FAIL store_half_ack: rdata=%h err=%b lat=%0d stable=%b expected 0 0 %0d 1",
                         obs_rdata, obs_err, obs_lat, obs_stable, exp_lat);
    end
  endtask

  task automatic test_timeout();
    drive_access(0, 0, 0, 0, 32'h200, 0, 32'h12345678, 100, 0);
    checks++;
    if (!obs_got || obs_en != TMO || obs_lat != TMO + 1 || obs_err !== 1'b1 || obs_rdata !== 0) begin
      errors++; $display("FAIL timeout: en=%0d lat=%0d err=%b rdata=%h expected %0d %0d 1 0",
                         obs_en, obs_lat, obs_err, obs_rdata, TMO, TMO + 1);
    end
    checks++;
    if (!obs_stable || obs_held_err !== 1'b1) begin
      errors++; $display("FAIL timeout_hold: stable=%b held_err=%b expected 1 1", obs_stable, obs_held_err);
    end
    drive_access(1, 0, 0, 0, 32'h300, 0, 32'hCAFEF00D, TMO - 1, 0);
    checks++;
    if (!obs_got || obs_en != TMO || obs_err !== 1'b0 || obs_rdata !== 32'hCAFEF00D) begin
      errors++; $display("FAIL timeout_edge_ready: en=%0d err=%b rdata=%h expected %0d 0 cafef00d",
                         obs_en, obs_err, obs_rdata, TMO);
    end
  endtask

  task automatic test_contention();
    int owners[$];
    logic [31:0] addrs[$];
    int n = 0;
    do_reset();
    @(negedge clk);
    if_req = 1; if_addr = 32'h200;
    dm_req = 1; dm_we = 0; dm_half = 0; dm_unsigned = 0; dm_addr = 32'h300;
    while (owners.size() < 4 && n < 60) begin
      @(posedge clk); n++; @(negedge clk);
      mem_ready = mem_en;
      mem_rdata = $urandom;
      if (mem_en && mem_ready) addrs.push_back(mem_addr);
      if (dm_ack) owners.push_back(1);
      if (if_ack) owners.push_back(0);
    end
    if_req = 0; dm_req = 0; mem_ready = 0;
    @(negedge clk); @(negedge clk);
    checks++;
    if (owners.size() != 4 || addrs.size() < 4) begin
      errors++; $display("FAIL contention_count: got %0d acks expected 4", owners.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        int want = (i % 2 == 0) ? 1 : 0;
        checks++;
        if (owners[i] != want || addrs[i] !== (want ? 32'h300 : 32'h200)) begin
          errors++; $display("FAIL contention_grant_%0d: owner=%0d addr=%h expected %0d %h",
                             i, owners[i], addrs[i], want, want ? 32'h300 : 32'h200);
        end
      end
    end
  endtask

  task automatic test_reset_mid_access();
    int n = 0;
    int acks = 0;
    @(negedge clk);
    dm_req = 1; dm_we = 0; dm_half = 0; dm_addr = 32'h10; mem_ready = 0;
    while (!mem_en && n < 10) begin
      @(negedge clk); n++;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (mem_en !== 1'b0 || dm_ack !== 1'b0 || n >= 10) begin
      errors++; $display("FAIL reset_mid_access: mem_en=%b dm_ack=%b waited=%0d expected 0 0 <10", mem_en, dm_ack, n);
    end
    @(negedge clk); dm_req = 0;
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dm_ack || if_ack || mem_en) acks++;
    end
    checks++;
    if (acks != 0) begin
      errors++; $display("FAIL reset_no_ack: got %0d active cycles expected 0", acks);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      bit          is_if = $urandom_range(0, 2) == 0;
      bit          we    = $urandom_range(0, 1);
      bit          half  = $urandom_range(0, 1);
      bit          uns   = $urandom_range(0, 1);
      logic [31:0] addr  = $urandom;
      logic [31:0] wdata = $urandom;
      logic [31:0] rword = $urandom;
      int          w     = ($urandom_range(0, 9) == 0) ? TMO + 2 : $urandom_range(0, 4);
      if ($urandom_range(0, 3) != 0) addr = addr & ~(half ? 32'h1 : 32'h3);
      model(is_if, we, half, uns, addr, wdata, rword, w);
      drive_access(is_if, we, half, uns, addr, wdata, rword, w, $urandom_range(0, 1));
      checks++;
      if (!obs_got || obs_wrong || obs_lat != exp_lat || obs_en != exp_en ||
          obs_rdata !== exp_rdata || obs_err !== exp_err) begin
        errors++; $display("FAIL rand_%0d_result: lat=%0d en=%0d rdata=%h err=%b wrong=%b expected %0d %0d %h %b",
                           t, obs_lat, obs_en, obs_rdata, obs_err, obs_wrong, exp_lat, exp_en, exp_rdata, exp_err);
      end
      if (exp_en > 0) begin
        checks++;
        if (obs_maddr !== exp_maddr || obs_be !== exp_be || obs_we !== exp_we ||
            obs_mwdata !== exp_mwdata || !obs_stable) begin
          errors++; $display("FAIL rand_%0d_port: addr=%h be=%h we=%b wdata=%h stable=%b expected %h %h %b %h 1",
                             t, obs_maddr, obs_be, obs_we, obs_mwdata, obs_stable,
                             exp_maddr, exp_be, exp_we, exp_mwdata);
        end
      end
      checks++;
      if (obs_ack_after !== 1'b0 || obs_held !== exp_rdata || obs_held_err !== exp_err) begin
        errors++; $display("FAIL rand_%0d_hold: ack_after=%b held=%h err=%b expected 0 %h %b",
                           t, obs_ack_after, obs_held, obs_held_err, exp_rdata, exp_err);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    test_reset();
    test_fetch_zero_wait();
    test_halfword_loads();
    test_misaligned();
    test_store_half();
    test_timeout();
    test_contention();
    test_reset_mid_access();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
